hit_address_encoder: RTL and testbench

HIT_ADDRESS_ENCODER -- requirements
Module: hit_address_encoder

---
 rtl/hit_address_encoder_pkg.sv | 19 +
 rtl/lowest_set_bit_encoder.sv | 20 ++
 rtl/hit_address_encoder.sv | 121 ++++++++++++
 tb/tb_hit_address_encoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hit_address_encoder_pkg.sv
// Shared parameter set (MyParameters) and types for the hit address encoder.
// Geometry constants live here only; every other file imports this package.
package hit_address_encoder_pkg;

    localparam int WORDLENGTH   = 16;
    localparam int COLINDEXBITS = 4;
    localparam int ROWINDEXBITS = 4;
    localparam int MEMNROWS     = 16;

    localparam int ADDRBITS  = ROWINDEXBITS + COLINDEXBITS;
    // One extra bit so a full readout of MEMNROWS*WORDLENGTH hits still fits.
    localparam int COUNTBITS = $clog2(MEMNROWS * WORDLENGTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// Combinational priority encoder: index of the lowest set bit of a word
// plus a flag telling whether any bit is set at all.
module lowest_set_bit_encoder
    import hit_address_encoder_pkg::*;
(
    input  logic [WORDLENGTH-1:0]   word,
    output logic [COLINDEXBITS-1:0] index,
    output logic                    valid
);

    // Walk from the top so the lowest set bit is the last one to win.
    always_comb begin
        index = {COLINDEXBITS{1'b0}};
        valid = |word;
        for (int i = WORDLENGTH - 1; i >= 0; i--) begin
            index = word[i] ? COLINDEXBITS'(i) : index;
        end
    end

endmodule

// File: rtl/hit_address_encoder.sv
// Accepts hit-bitmap rows and hands out one {row, letter} address per set bit,
// lowest letter first, with readout completion and hit counting.
module hit_address_encoder
    import hit_address_encoder_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rowValid,
    input  logic [ROWINDEXBITS-1:0] rowIndex,
    input  logic [WORDLENGTH-1:0]   rowWord,
    input  logic                    lastRow,
    output logic                    rowReady,
    output logic                    hitValid,
    output logic [ADDRBITS-1:0]     hitAddress,
    input  logic                    hitReady,
    output logic                    hitLast,
    output logic                    readoutDone,
    output logic [COUNTBITS-1:0]    hitCount
);

    state_t                  state_q, state_d;
    logic [WORDLENGTH-1:0]   word_q, word_d;
    logic [ROWINDEXBITS-1:0] row_q, row_d;
    logic                    last_q, last_d;
    logic                    row_ready_q, row_ready_d;
    logic                    hit_valid_q, hit_valid_d;
    logic [ADDRBITS-1:0]     hit_address_q, hit_address_d;
    logic                    hit_last_q, hit_last_d;
    logic                    readout_done_q, readout_done_d;
    logic [COUNTBITS-1:0]    hit_count_q, hit_count_d;
    logic                    done_seen_q, done_seen_d;

    logic                    accept_s;
    logic                    handshake_s;
    logic [COLINDEXBITS-1:0] next_index_s;
    logic                    next_valid_s;

    lowest_set_bit_encoder u_lsb (
        .word  (word_d),
        .index (next_index_s),
        .valid (next_valid_s)
    );

    // Next-state: the encoder looks at the upcoming working word so the
    // hit outputs can be registered without an extra cycle of latency.
    always_comb begin
        accept_s       = rowValid && row_ready_q;
        handshake_s    = hit_valid_q && hitReady;
        state_d        = state_q;
        word_d         = word_q;
        row_d          = row_q;
        last_d         = last_q;
        hit_count_d    = hit_count_q;
        done_seen_d    = done_seen_q;
        readout_done_d = 1'b0;
        if (accept_s) begin
            row_d          = rowIndex;
            last_d         = lastRow;
            word_d         = rowWord;
            hit_count_d    = done_seen_q ? {COUNTBITS{1'b0}} : hit_count_q;
            readout_done_d = (rowWord == {WORDLENGTH{1'b0}}) && lastRow;
            done_seen_d    = readout_done_d;
            state_d        = (rowWord != {WORDLENGTH{1'b0}}) ? SCAN : IDLE;
        end else if (handshake_s) begin
            // Clearing the lowest set bit retires exactly the hit just taken.
            word_d      = word_q & (word_q - WORDLENGTH'(1));
            hit_count_d = hit_count_q + COUNTBITS'(1);
            if (word_d == {WORDLENGTH{1'b0}}) begin
                state_d        = IDLE;
                readout_done_d = last_q;
                done_seen_d    = last_q;
            end else begin
                state_d = SCAN;
            end
        end else begin
            state_d = state_q;
        end
        row_ready_d   = (state_d == IDLE);
        hit_valid_d   = (state_d == SCAN) && next_valid_s;
        hit_address_d = {row_d, next_index_s};
        hit_last_d    = hit_valid_d && last_d &&
                        ((word_d & (word_d - WORDLENGTH'(1))) == {WORDLENGTH{1'b0}});
    end

    // State and registered outputs; reset discards any partial row.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            word_q         <= {WORDLENGTH{1'b0}};
            row_q          <= {ROWINDEXBITS{1'b0}};
            last_q         <= 1'b0;
            row_ready_q    <= 1'b1;
            hit_valid_q    <= 1'b0;
            hit_address_q  <= {ADDRBITS{1'b0}};
            hit_last_q     <= 1'b0;
            readout_done_q <= 1'b0;
            hit_count_q    <= {COUNTBITS{1'b0}};
            done_seen_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_q         <= word_d;
            row_q          <= row_d;
            last_q         <= last_d;
            row_ready_q    <= row_ready_d;
            hit_valid_q    <= hit_valid_d;
            hit_address_q  <= hit_address_d;
            hit_last_q     <= hit_last_d;
            readout_done_q <= readout_done_d;
            hit_count_q    <= hit_count_d;
            done_seen_q    <= done_seen_d;
        end
    end

    assign rowReady    = row_ready_q;
    assign hitValid    = hit_valid_q;
    assign hitAddress  = hit_address_q;
    assign hitLast     = hit_last_q;
    assign readoutDone = readout_done_q;
    assign hitCount    = hit_count_q;

endmodule

// File: tb/tb_hit_address_encoder.sv
// Directed bench: stimulus pushes expected {hitLast, hitAddress} into a queue,
// a negedge monitor pops and compares on every hit handshake.
module tb_hit_address_encoder;

    logic       clock = 1'b0;
    logic       reset;
    logic       rowValid;
    logic [3:0] rowIndex;
    logic [15:0] rowWord;
    logic       lastRow;
    logic       rowReady;
    logic       hitValid;
    logic [7:0] hitAddress;
    logic       hitReady;
    logic       hitLast;
    logic       readoutDone;
    logic [8:0] hitCount;

    int n_vec  = 0;
    int n_err  = 0;
    int done_pulses = 0;
    logic [8:0] sb[$];

    hit_address_encoder dut (
        .clock       (clock),
        .reset       (reset),
        .rowValid    (rowValid),
        .rowIndex    (rowIndex),
        .rowWord     (rowWord),
        .lastRow     (lastRow),
        .rowReady    (rowReady),
        .hitValid    (hitValid),
        .hitAddress  (hitAddress),
        .hitReady    (hitReady),
        .hitLast     (hitLast),
        .readoutDone (readoutDone),
        .hitCount    (hitCount)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each handed-off hit against the scoreboard head.
    always @(negedge clock) begin
        if (!reset) begin
            if (readoutDone) done_pulses++;
            if (hitValid && hitReady) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_hit: got 0x%0h expected none", {hitLast, hitAddress});
                end else begin
                    check("hit", {23'd0, hitLast, hitAddress}, {23'd0, sb.pop_front()});
                end
            end
        end
    end

    task automatic send_row(input logic [3:0] row, input logic [15:0] word, input logic last);
        int t = 0;
        int hi = -1;
        while (!rowReady && t < 100) begin
            @(posedge clock); #1;
            t++;
        end
        if (!rowReady) check("row_ready_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 16; i++) if (word[i]) hi = i;
        for (int i = 0; i < 16; i++)
            if (word[i]) sb.push_back({last && (i == hi), row, 4'(i)});
        rowValid = 1'b1;
        rowIndex = row;
        rowWord  = word;
        lastRow  = last;
        @(posedge clock); #1;
        rowValid = 1'b0;
        rowWord  = 16'h0;
        lastRow  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || !rowReady) && t < 200) begin
            @(posedge clock); #1;
            t++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        int d0;
        reset    = 1'b1;
        rowValid = 1'b0;
        rowIndex = 4'h0;
        rowWord  = 16'h0;
        lastRow  = 1'b0;
        hitReady = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rowReady", rowReady, 32'd1);
        check("rst_hitValid", hitValid, 32'd0);
        check("rst_hitLast", hitLast, 32'd0);
        check("rst_readoutDone", readoutDone, 32'd0);
        check("rst_hitCount", hitCount, 32'd0);
        check("rst_hitAddress", hitAddress, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Row 3, 0x8001: two back-to-back hits, then ready again.
        send_row(4'd3, 16'h8001, 1'b0);
        check("r3_valid0", hitValid, 32'd1);
        check("r3_addr0", hitAddress, 32'h30);
        check("r3_busy", rowReady, 32'd0);
        @(posedge clock); #1;
        check("r3_valid1", hitValid, 32'd1);
        check("r3_addr1", hitAddress, 32'h3F);
        @(posedge clock); #1;
        check("r3_ready_after", rowReady, 32'd1);
        check("r3_idle_valid", hitValid, 32'd0);

        // Row 3, 0x0011 with backpressure: first hit must hold.
        hitReady = 1'b0;
        send_row(4'd3, 16'h0011, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", hitValid, 32'd1);
            check("stall_addr", hitAddress, 32'h30);
            check("stall_last", hitLast, 32'd0);
            if (k < 4) begin
                @(posedge clock); #1;
            end
        end
        hitReady = 1'b1;
        @(posedge clock); #1;
        check("stall_next_addr", hitAddress, 32'h34);
        drain();

        // Row 5, zero word, lastRow: done pulse only.
        do_reset();
        d0 = done_pulses;
        send_row(4'd5, 16'h0000, 1'b1);
        check("zero_done", readoutDone, 32'd1);
        check("zero_valid", hitValid, 32'd0);
        check("zero_count", hitCount, 32'd0);
        check("zero_ready", rowReady, 32'd1);
        @(posedge clock); #1;
        check("zero_done_drop", readoutDone, 32'd0);

        // Row 15, full word, lastRow: 16 hits, one done pulse.
        d0 = done_pulses;
        send_row(4'd15, 16'hFFFF, 1'b1);
        check("full_count_cleared", hitCount, 32'd0);
        drain();
        repeat (2) @(posedge clock);
        #1;
        check("full_count", hitCount, 32'd16);
        check("full_done_pulses", done_pulses - d0, 32'd1);

        // Row 7, reset after two handshakes discards the rest.
        send_row(4'd7, 16'h00F0, 1'b0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("r7_addr_before_rst", hitAddress, 32'h76);
        reset = 1'b1;
        #1;
        check("r7_rst_valid", hitValid, 32'd0);
        check("r7_rst_addr", hitAddress, 32'd0);
        check("r7_rst_count", hitCount, 32'd0);
        check("r7_rst_ready", rowReady, 32'd1);
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            check("r7_post_valid", hitValid, 32'd0);
        end
        check("r7_post_count", hitCount, 32'd0);
        check("r7_post_ready", rowReady, 32'd1);

        // Rows 1 and 2 back to back, then a new row clears the count.
        d0 = done_pulses;
        send_row(4'd1, 16'h0004, 1'b0);
        send_row(4'd2, 16'h0100, 1'b1);
        drain();
        repeat (2) @(posedge clock);
        #1;
        check("pair_count", hitCount, 32'd2);
        check("pair_done_pulses", done_pulses - d0, 32'd1);
        send_row(4'd4, 16'h0001, 1'b0);
        check("pair_count_clear", hitCount, 32'd0);
        drain();
        check("single_count", hitCount, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
